// File: rtl/audio_sfx_mixer.sv
// Multi-channel sound-effect mixer: per-channel ROM clip playback, attenuation,
// signed summation with saturation, one mixed sample per codec request.
module audio_sfx_mixer #(
  parameter int NUM_CH = 4,
  parameter int ROM_AW = 15,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW = CHW + 2,
  localparam int ACCW = 17 + CHW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [AW-1:0]     address,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  input  logic              sample_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_q,
  output logic [15:0]       audio_output,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OUT = 2'd2} state_t;

  localparam logic [CHW:0] LAST_SLOT = (CHW+1)'(NUM_CH);
  localparam logic signed [ACCW-1:0] MAX_V = ACCW'(32767);
  localparam logic signed [ACCW-1:0] MIN_V = -ACCW'(32768);

  state_t state, state_n;
  logic [CHW:0]            slot, slot_m1;
  logic signed [ACCW-1:0]  acc;

  // ctrl_r holds CTRL[6:1]: [0] loop, [4:1] atten, [5] irq_en
  logic [ROM_AW-1:0] start_r [NUM_CH];
  logic [15:0]       len_r   [NUM_CH];
  logic [5:0]        ctrl_r  [NUM_CH];
  logic [15:0]       pos_r   [NUM_CH];
  logic [NUM_CH-1:0] active, done, irq_en;

  logic [CHW-1:0] bus_ch, seq_ch;
  logic [1:0]     bus_reg;
  logic           bus_ch_ok, bus_wr, seq_fire;
  logic [NUM_CH-1:0] wr_start, wr_len, wr_ctrl, wr_stat, seq_hit, seq_end;
  logic signed [15:0]     shifted;
  logic signed [ACCW-1:0] sample_ext;
  logic [15:0]            sat;

  // Avalon-MM slave, no waitrequest: a write commits on the clock edge where
  // chipselect&write are high; read data is combinational (latency 0).
  assign bus_ch    = address[AW-1:2];
  assign bus_reg   = address[1:0];
  assign bus_ch_ok = int'(bus_ch) < NUM_CH;
  assign bus_wr    = chipselect && write && bus_ch_ok;

  assign fsm_state = state;
  assign slot_m1   = slot - (CHW+1)'(1);
  assign seq_ch    = slot_m1[CHW-1:0];
  // The accumulate edge for channel k is the end of slot k+1.
  assign seq_fire  = (state == S_RUN) && (slot != '0);

  assign shifted    = $signed(rom_q) >>> ctrl_r[seq_ch][4:1];
  assign sample_ext = ACCW'(shifted);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (sample_req) state_n = S_RUN;
      S_RUN:   if (slot == LAST_SLOT) state_n = S_OUT;
      S_OUT:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rom_addr = '0;
    if (state == S_RUN && slot < LAST_SLOT)
      rom_addr = start_r[slot[CHW-1:0]] + pos_r[slot[CHW-1:0]][ROM_AW-1:0];
  end

  always_comb begin
    if (acc > MAX_V)      sat = 16'h7FFF;
    else if (acc < MIN_V) sat = 16'h8000;
    else                  sat = acc[15:0];
  end

  always_comb begin
    wr_start = '0;
    wr_len   = '0;
    wr_ctrl  = '0;
    wr_stat  = '0;
    seq_hit  = '0;
    seq_end  = '0;
    irq_en   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus_wr && int'(bus_ch) == i) begin
        wr_start[i] = (bus_reg == 2'd0);
        wr_len[i]   = (bus_reg == 2'd1);
        wr_ctrl[i]  = (bus_reg == 2'd2);
        wr_stat[i]  = (bus_reg == 2'd3);
      end
      seq_hit[i] = seq_fire && int'(seq_ch) == i && active[i];
      // >= rather than == so a LENGTH shrunk below pos still ends the clip
      seq_end[i] = ({1'b0, pos_r[i]} + 17'd1) >= {1'b0, len_r[i]};
      irq_en[i]  = ctrl_r[i][5];
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect && read && bus_ch_ok) begin
      case (bus_reg)
        2'd0:    readdata[ROM_AW-1:0] = start_r[bus_ch];
        2'd1:    readdata = len_r[bus_ch];
        2'd2:    readdata[6:0] = {ctrl_r[bus_ch], active[bus_ch]};
        default: readdata[1:0] = {active[bus_ch], done[bus_ch]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      slot         <= '0;
      acc          <= '0;
      audio_output <= '0;
      irq          <= 1'b0;
    end else begin
      state <= state_n;
      irq   <= |(done & irq_en);
      case (state)
        S_IDLE: if (sample_req) begin
          acc  <= '0;
          slot <= '0;
        end
        S_RUN: begin
          slot <= slot + (CHW+1)'(1);
          if (seq_fire && active[seq_ch]) acc <= acc + sample_ext;
        end
        S_OUT:   audio_output <= sat;
        default: ;
      endcase
    end
  end

  // CPU CTRL writes override the sequencer's pos/active update; a done set
  // from the sequencer beats any done clear in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        start_r[i] <= '0;
        len_r[i]   <= '0;
        ctrl_r[i]  <= '0;
        pos_r[i]   <= '0;
      end
      active <= '0;
      done   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_start[i]) start_r[i] <= writedata[ROM_AW-1:0];
        if (wr_len[i])   len_r[i]   <= writedata;
        if (wr_ctrl[i]) begin
          ctrl_r[i] <= writedata[6:1];
          if (!writedata[0]) begin
            active[i] <= 1'b0;
          end else if (len_r[i] != 16'd0) begin
            pos_r[i]  <= '0;
            active[i] <= 1'b1;
          end
        end else if (seq_hit[i]) begin
          if (!seq_end[i])     pos_r[i]  <= pos_r[i] + 16'd1;
          else if (ctrl_r[i][0]) pos_r[i] <= '0;
          else                 active[i] <= 1'b0;
        end
        if (seq_hit[i] && seq_end[i] && !ctrl_r[i][0])
          done[i] <= 1'b1;
        else if ((wr_ctrl[i] && writedata[0] && len_r[i] != 16'd0) ||
                 (wr_stat[i] && writedata[0]))
          done[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_sfx_mixer.sv
// Bench for audio_sfx_mixer: behavioural sample ROM, Avalon-MM driver tasks,
// expected-sample queue checked at the exact output-update cycle.
module tb_audio_sfx_mixer;

  localparam int NUM_CH = 4;
  localparam int ROM_AW = 15;
  localparam int AW     = 4;
  localparam int LAT    = NUM_CH + 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              chipselect, write, read;
  logic [AW-1:0]     address;
  logic [15:0]       writedata, readdata;
  logic              irq, sample_req;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_q, audio_output;
  logic [1:0]        fsm_state;

  logic [15:0]       rom [0:(1<<ROM_AW)-1];
  logic [15:0]       exp_q [$];
  logic [15:0]       last_out;
  logic [ROM_AW-1:0] seen_addr [0:NUM_CH-1];
  logic [15:0]       rd;
  int                n_total = 0;
  int                n_bad = 0;

  audio_sfx_mixer #(.NUM_CH(NUM_CH), .ROM_AW(ROM_AW)) dut (
    .clk(clk), .resetn(resetn), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata), .readdata(readdata),
    .irq(irq), .sample_req(sample_req), .rom_addr(rom_addr), .rom_q(rom_q),
    .audio_output(audio_output), .fsm_state(fsm_state)
  );

  // clock / ROM
  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    #1 d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_total++; n_bad++;
      $display("FAIL %s: got=%0h expected=<empty queue>", tag, audio_output);
    end else begin
      e = exp_q.pop_front();
      check(tag, audio_output, e);
      last_out = e;
    end
  endtask

  // One request; output must hold through edge LAT-1 and update at edge LAT.
  task automatic play(input logic [15:0] e);
    exp_q.push_back(e);
    pulse_req();
    seen_addr[0] = rom_addr;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      if (k < NUM_CH) seen_addr[k] = rom_addr;
      if (k == LAT - 1) check("hold", audio_output, last_out);
      if (k == LAT) pop_check("audio");
    end
  endtask

  initial begin
    #2_000_000;
    n_total++; n_bad++;
    $display("FAIL timeout: got=running expected=finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    for (int i = 0; i < (1 << ROM_AW); i++) rom[i] = 16'h0000;
    rom[15'h100] = 16'd100; rom[15'h101] = 16'd200; rom[15'h102] = 16'd300;
    rom[15'h200] = 16'd5;   rom[15'h201] = 16'd7;
    rom[15'h300] = 16'd30000; rom[15'h301] = 16'(-30000);
    rom[15'h7FFF] = 16'd11; rom[15'h0000] = 16'd13;
    resetn = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; sample_req = 1'b0; last_out = 16'h0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_audio", audio_output, 16'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_rom_addr", rom_addr, 15'h0);
    check("rst_fsm", fsm_state, 2'd0);
    bus_read(4'd1, rd);
    check("rst_len", rd, 16'h0);
    @(negedge clk) resetn = 1'b1;

    // one-shot clip, irq enabled
    bus_write(4'd0, 16'h0100);
    bus_write(4'd1, 16'd3);
    bus_write(4'd2, 16'h0041);
    play(16'd100);
    play(16'd200);
    play(16'd300);
    bus_read(4'd3, rd);
    check("oneshot_status", rd, 16'h1);
    bus_read(4'd2, rd);
    check("oneshot_ctrl", rd, 16'h0040);
    check("oneshot_irq", irq, 1'b1);
    play(16'd0);
    bus_write(4'd3, 16'h0001);
    check("irq_lag", irq, 1'b1);
    @(posedge clk);
    #1 check("irq_clear", irq, 1'b0);
    bus_read(4'd3, rd);
    check("done_clear", rd, 16'h0);

    // looping clip and retrigger
    bus_write(4'd0, 16'h0200);
    bus_write(4'd1, 16'd2);
    bus_write(4'd2, 16'h0003);
    for (int n = 0; n < 4; n++) play((n % 2 == 0) ? 16'd5 : 16'd7);
    bus_read(4'd3, rd);
    check("loop_status", rd, 16'h2);
    play(16'd5);
    bus_write(4'd2, 16'h0003);
    play(16'd5);
    bus_write(4'd2, 16'h0000);

    // two-channel mixing and saturation
    bus_write(4'd0, 16'h0300); bus_write(4'd1, 16'd1); bus_write(4'd2, 16'h0003);
    bus_write(4'd4, 16'h0300); bus_write(4'd5, 16'd1); bus_write(4'd6, 16'h0003);
    play(16'h7FFF);
    bus_write(4'd6, 16'h0007);
    play(16'h7FFF);
    bus_write(4'd6, 16'h0003);
    bus_write(4'd0, 16'h0301);
    bus_write(4'd4, 16'h0301);
    play(16'h8000);
    bus_write(4'd0, 16'h0101);
    bus_write(4'd6, 16'h0013);
    play(16'(-1675));
    bus_write(4'd2, 16'h0000);
    bus_write(4'd6, 16'h0000);

    // ROM address wrap on channel 2, irq disabled
    bus_write(4'd8, 16'h7FFF);
    bus_write(4'd9, 16'd2);
    bus_write(4'd10, 16'h0001);
    play(16'd11);
    check("wrap_addr0", seen_addr[2], 15'h7FFF);
    play(16'd13);
    check("wrap_addr1", seen_addr[2], 15'h0000);
    bus_read(4'd11, rd);
    check("wrap_status", rd, 16'h1);
    check("wrap_no_irq", irq, 1'b0);

    // request while busy is ignored
    bus_write(4'd12, 16'h0200);
    bus_write(4'd13, 16'd2);
    bus_write(4'd14, 16'h0003);
    exp_q.push_back(16'd5);
    pulse_req();
    @(posedge clk);
    pulse_req();
    repeat (LAT - 2) @(posedge clk);
    #1 pop_check("busy_first");
    repeat (2) @(posedge clk);
    #1 check("busy_ignored", audio_output, 16'd5);
    play(16'd7);
    play(16'd5);

    // reset in the middle of a run
    pulse_req();
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("abort_audio", audio_output, 16'h0);
    check("abort_fsm", fsm_state, 2'd0);
    @(negedge clk) resetn = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    check("abort_no_update", audio_output, 16'h0);
    check("abort_idle", fsm_state, 2'd0);
    bus_read(4'd14, rd);
    check("abort_ctrl", rd, 16'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
